// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO with a valid/ready push port feeds a
// frame serialiser. Data width, parity, stop-bit count and bit period are
// configurable.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic [1:0]                    parity_type,
  input  logic                          stop_bits,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          out,
  output logic                          sending,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   two_stop_q, two_stop_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ready_q, ready_d;
  logic                   out_q, out_d;
  logic                   sending_q, sending_d;
  logic                   done_q, done_d;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                   push_c;
  logic                   pop_c;
  logic                   bit_end_c;
  logic                   state_end_c;
  logic [DIV_WIDTH-1:0]   eff_div_c;
  logic [DATA_BITS-1:0]   word_c;

  assign push_c      = din_valid & ready_q;
  assign bit_end_c   = (baud_q == '0);
  assign state_end_c = bit_end_c && (bit_q == '0);
  assign eff_div_c   = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;
  assign word_c      = mem_q[rd_ptr_q];

  // Serialiser FSM: bit timing, state sequencing, pop and config capture
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    sh_d       = sh_q;
    pop_c      = 1'b0;

    if (state_q != S_IDLE && !state_end_c) begin
      if (!bit_end_c) begin
        baud_d = baud_q - DIV_WIDTH'(1);
      end else begin
        bit_d  = bit_q - BIT_W'(1);
        baud_d = div_q - DIV_WIDTH'(1);
        if (state_q == S_DATA) sh_d = sh_q >> 1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (state_end_c) begin
          state_d = S_DATA;
          bit_d   = BIT_W'(DATA_BITS - 1);
          baud_d  = div_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (state_end_c) begin
          baud_d = div_q - DIV_WIDTH'(1);
          if (par_en_q) begin
            state_d = S_PARITY;
            bit_d   = '0;
          end else begin
            state_d = S_STOP;
            bit_d   = BIT_W'(two_stop_q);
          end
        end
      end
      S_PARITY: begin
        if (state_end_c) begin
          state_d = S_STOP;
          bit_d   = BIT_W'(two_stop_q);
          baud_d  = div_q - DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (state_end_c) begin
          if (count_q != '0) begin
            pop_c   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop loads the word and freezes the line settings for this frame
    if (pop_c) begin
      sh_d       = word_c;
      div_d      = eff_div_c;
      par_en_d   = parity_type[0] ^ parity_type[1];
      par_bit_d  = (parity_type == 2'b01) ? ~(^word_c) : ^word_c;
      two_stop_d = stop_bits;
      baud_d     = eff_div_c - DIV_WIDTH'(1);
      bit_d      = '0;
    end
  end

  // Registered line level and status, derived from the upcoming state
  always_comb begin
    out_d = 1'b1;
    case (state_d)
      S_START:  out_d = 1'b0;
      S_DATA:   out_d = sh_d[0];
      S_PARITY: out_d = par_bit_d;
      default:  out_d = 1'b1;
    endcase
    sending_d = (state_d != S_IDLE);
    done_d    = (state_d == S_STOP) && (baud_d == '0) && (bit_d == '0);
  end

  // FIFO pointer, occupancy and ready bookkeeping
  always_comb begin
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // Control and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      div_q      <= DIV_WIDTH'(2);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      sh_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      out_q      <= 1'b1;
      sending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      sh_q       <= sh_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      out_q      <= out_d;
      sending_q  <= sending_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage; contents are invalidated by the pointer reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= din;
  end

  assign din_ready  = ready_q;
  assign out        = out_q;
  assign sending    = sending_q;
  assign frame_done = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit and 5-bit instances.
module tb_uart_tx_fifo;

  logic        clk;
  logic        reset;
  logic [15:0] divisor;
  logic [1:0]  parity_type;
  logic        stop_bits;

  logic [7:0]  din8;
  logic        valid8, ready8, out8, snd8, done8;
  logic [2:0]  cnt8;
  logic [4:0]  din5;
  logic        valid5, ready5, out5, snd5, done5;
  logic [2:0]  cnt5;

  int checks   = 0;
  int failures = 0;

  logic cap_out  [128];
  logic cap_snd  [128];
  logic cap_done [128];
  int   cap_cnt  [128];

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut8 (
    .clk(clk), .reset(reset), .divisor(divisor), .parity_type(parity_type),
    .stop_bits(stop_bits), .din(din8), .din_valid(valid8), .din_ready(ready8),
    .out(out8), .sending(snd8), .frame_done(done8), .fifo_count(cnt8)
  );

  uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut5 (
    .clk(clk), .reset(reset), .divisor(divisor), .parity_type(parity_type),
    .stop_bits(stop_bits), .din(din5), .din_valid(valid5), .din_ready(ready5),
    .out(out5), .sending(snd5), .frame_done(done5), .fifo_count(cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records one instance's outputs for n cycles after the current edge
  task automatic capture(input bit use5, input int n, input int chg_idx, input logic [15:0] chg_div);
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) begin
        valid8 = 1'b0;
        valid5 = 1'b0;
      end
      if (i == chg_idx) divisor = chg_div;
      cap_out[i]  = use5 ? out5 : out8;
      cap_snd[i]  = use5 ? snd5 : snd8;
      cap_done[i] = use5 ? done5 : done8;
      cap_cnt[i]  = use5 ? int'(cnt5) : int'(cnt8);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out8 !== 1'b1) begin failures++; $display("FAIL reset_out got=%b exp=1", out8); end
    checks++; if (snd8 !== 1'b0) begin failures++; $display("FAIL reset_sending got=%b exp=0", snd8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", done8); end
    checks++; if (ready8 !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b exp=1", ready8); end
    checks++; if (cnt8 !== 3'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", cnt8); end
    checks++; if (out5 !== 1'b1) begin failures++; $display("FAIL reset_out5 got=%b exp=1", out5); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  // Single frame: seq lists expected line levels, one per bit, start first
  task automatic test_frame(input string name, input bit use5, input logic [7:0] word,
                            input logic [15:0] div, input logic [1:0] par, input logic stp,
                            input int nbits, input logic [0:11] seq,
                            input int chg_idx, input logic [15:0] chg_div);
    int   eff, total, ndone;
    logic e_out, e_snd, e_done;
    eff   = (div < 16'd2) ? 2 : int'(div);
    total = nbits * eff;
    divisor = div; parity_type = par; stop_bits = stp;
    if (use5) begin din5 = word[4:0]; valid5 = 1'b1; end
    else      begin din8 = word;      valid8 = 1'b1; end
    capture(use5, total + 4, chg_idx, chg_div);
    checks++; if (cap_cnt[0] !== 1) begin failures++; $display("FAIL %s count_after_push got=%0d exp=1", name, cap_cnt[0]); end
    checks++; if (cap_cnt[1] !== 0) begin failures++; $display("FAIL %s count_after_pop got=%0d exp=0", name, cap_cnt[1]); end
    ndone = 0;
    for (int i = 0; i < total + 4; i++) begin
      e_snd  = (i >= 1) && (i <= total);
      e_out  = e_snd ? seq[(i - 1) / eff] : 1'b1;
      e_done = (i == total);
      if (cap_done[i] === 1'b1) ndone++;
      checks++; if (cap_out[i] !== e_out) begin failures++; $display("FAIL %s out[%0d] got=%b exp=%b", name, i, cap_out[i], e_out); end
      checks++; if (cap_snd[i] !== e_snd) begin failures++; $display("FAIL %s sending[%0d] got=%b exp=%b", name, i, cap_snd[i], e_snd); end
      checks++; if (cap_done[i] !== e_done) begin failures++; $display("FAIL %s frame_done[%0d] got=%b exp=%b", name, i, cap_done[i], e_done); end
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL %s done_pulses got=%0d exp=1", name, ndone); end
  endtask

  // Six words offered on consecutive cycles into a depth-4 FIFO, divisor 2
  task automatic test_back_to_back();
    logic [7:0] w [6];
    int   exp_cnt [6];
    logic e_out, e_snd, e_done;
    logic [7:0] wd;
    int   p, f, b, ndone;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2; exp_cnt[3] = 3; exp_cnt[4] = 4; exp_cnt[5] = 4;
    divisor = 16'd2; parity_type = 2'b00; stop_bits = 1'b0;
    ndone = 0;
    for (int j = 0; j < 104; j++) begin
      if (j < 6) begin
        din8 = w[j]; valid8 = 1'b1;
        checks++; if (ready8 !== (j < 5)) begin failures++; $display("FAIL b2b din_ready[%0d] got=%b exp=%b", j, ready8, (j < 5)); end
      end
      step();
      if (j == 5) valid8 = 1'b0;
      if (j < 6) begin
        checks++; if (int'(cnt8) !== exp_cnt[j]) begin failures++; $display("FAIL b2b fifo_count[%0d] got=%0d exp=%0d", j, cnt8, exp_cnt[j]); end
      end
      e_snd = (j >= 1) && (j <= 100);
      e_out = 1'b1;
      if (e_snd) begin
        p  = (j - 1) / 2;
        f  = p / 10;
        b  = p % 10;
        wd = w[f];
        e_out = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : wd[b - 1];
      end
      e_done = (j >= 20) && (j <= 100) && (j % 20 == 0);
      if (done8 === 1'b1) ndone++;
      checks++; if (out8 !== e_out) begin failures++; $display("FAIL b2b out[%0d] got=%b exp=%b", j, out8, e_out); end
      checks++; if (snd8 !== e_snd) begin failures++; $display("FAIL b2b sending[%0d] got=%b exp=%b", j, snd8, e_snd); end
      checks++; if (done8 !== e_done) begin failures++; $display("FAIL b2b frame_done[%0d] got=%b exp=%b", j, done8, e_done); end
    end
    checks++; if (ndone !== 5) begin failures++; $display("FAIL b2b done_pulses got=%0d exp=5", ndone); end
    checks++; if (cnt8 !== 3'd0) begin failures++; $display("FAIL b2b final_count got=%0d exp=0", cnt8); end
  endtask

  // Asynchronous reset during the data bits of the second queued frame
  task automatic test_reset_mid_frame();
    logic [7:0] w [3];
    w[0] = 8'hF0; w[1] = 8'h00; w[2] = 8'hFF;
    divisor = 16'd2; parity_type = 2'b00; stop_bits = 1'b0;
    for (int j = 0; j < 3; j++) begin
      din8 = w[j]; valid8 = 1'b1;
      step();
    end
    valid8 = 1'b0;
    repeat (25) step();
    checks++; if (out8 !== 1'b0) begin failures++; $display("FAIL rst_mid pre_out got=%b exp=0", out8); end
    checks++; if (cnt8 !== 3'd1) begin failures++; $display("FAIL rst_mid pre_count got=%0d exp=1", cnt8); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (out8 !== 1'b1) begin failures++; $display("FAIL rst_mid out got=%b exp=1", out8); end
    checks++; if (snd8 !== 1'b0) begin failures++; $display("FAIL rst_mid sending got=%b exp=0", snd8); end
    checks++; if (cnt8 !== 3'd0) begin failures++; $display("FAIL rst_mid fifo_count got=%0d exp=0", cnt8); end
    checks++; if (ready8 !== 1'b1) begin failures++; $display("FAIL rst_mid din_ready got=%b exp=1", ready8); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (out8 !== 1'b1) begin failures++; $display("FAIL rst_mid idle_out got=%b exp=1", out8); end
  endtask

  initial begin
    reset = 1'b1; divisor = 16'd4; parity_type = 2'b00; stop_bits = 1'b0;
    din8 = '0; valid8 = 1'b0; din5 = '0; valid5 = 1'b0;
    test_reset();
    test_frame("8n1_a5",   1'b0, 8'hA5, 16'd4, 2'b00, 1'b0, 10, 12'b010100101100, -1, 16'd0);
    test_frame("8o2_a5",   1'b0, 8'hA5, 16'd3, 2'b01, 1'b1, 12, 12'b010100101111, -1, 16'd0);
    test_frame("8e2_a5",   1'b0, 8'hA5, 16'd3, 2'b10, 1'b1, 12, 12'b010100101011, -1, 16'd0);
    test_frame("par11_a5", 1'b0, 8'hA5, 16'd2, 2'b11, 1'b0, 10, 12'b010100101100, -1, 16'd0);
    test_back_to_back();
    test_reset_mid_frame();
    test_frame("after_rst", 1'b0, 8'hC3, 16'd4, 2'b00, 1'b0, 10, 12'b011000011100, -1, 16'd0);
    test_frame("div0_3c",   1'b0, 8'h3C, 16'd0, 2'b00, 1'b0, 10, 12'b000111100100, -1, 16'd0);
    test_frame("div1_81",   1'b0, 8'h81, 16'd1, 2'b00, 1'b0, 10, 12'b010000001100, -1, 16'd0);
    test_frame("divchg_5a", 1'b0, 8'h5A, 16'd3, 2'b00, 1'b0, 10, 12'b001011010100, 5, 16'd7);
    test_frame("5n1_13",    1'b1, 8'h13, 16'd2, 2'b00, 1'b0, 7,  12'b011001100000, -1, 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter: a FIFO front end with a valid/ready handshake feeds a frame serialiser whose data width, parity mode, stop-bit count and bit period are configurable. The baud-rate generation and parity computation are handled inside this block, so it forms a complete transmit channel. The serial output drives the board TX pin, and `sending` drives the status LED/logic. This block supersedes the fixed 8-bit, unbuffered transmit path.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5..8.
- `FIFO_DEPTH`, 4: transmit buffer entries; power of two, at least 2.
- `DIV_WIDTH`, 16: width of the `divisor` input.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `divisor` input DIV_WIDTH: clk cycles per serial bit; values below 2 are treated as 2.
- `parity_type` input 2: 00 none, 01 odd, 10 even, 11 none.
- `stop_bits` input 1: 0 selects one stop bit, 1 selects two.
- `din` input DATA_BITS: word to transmit.
- `din_valid` input 1: `din` is offered.
- `din_ready` output 1: FIFO can accept a word; equals not full.
- `out` output 1: serial line, idle high.
- `sending` output 1: high while a frame is on the line.
- `frame_done` output 1: one-cycle pulse on the last cycle of the final stop bit.
- `fifo_count` output clog2(FIFO_DEPTH)+1: number of words held in the FIFO.

## Operation
- Push: when `din_valid` and `din_ready` are both high at a rising edge, `din` is written and `fifo_count` increments.
- Pop: the FSM removes a word in IDLE when the FIFO is non-empty.
- Simultaneous push and pop leave `fifo_count` unchanged.
- When full, `din_ready` is 0 and `din` is ignored, even if a pop happens in the same cycle.
- `divisor`, `parity_type` and `stop_bits` are sampled at the pop. Changes during a frame take effect on the next frame.
- FSM states and transitions:
  - IDLE to START when the FIFO is non-empty.
  - START to DATA.
  - DATA to PARITY when parity is enabled, otherwise to STOP.
  - PARITY to STOP.
  - STOP to START when the FIFO is non-empty, otherwise to IDLE.
- Each state lasts `divisor` cycles, except DATA (DATA_BITS times `divisor`) and STOP (one or two times `divisor`).
- The bit counter is reloaded at every state entry. The baud counter restarts at each pop, so there is no phase carry-over between frames.
- Line levels per state:
  - START drives 0.
  - DATA sends LSB first.
  - With odd parity, the ones count of data plus parity bit is odd. With even parity, that count is even.
  - STOP drives 1.
  - IDLE drives 1.
- Frame length in bits is 1 + DATA_BITS + p + s, where p is the parity bit count (0 or 1) and s the stop bit count (1 or 2).
- `sending` is 1 from the first cycle of START through the last cycle of STOP. It stays continuously 1 across back-to-back frames.

## Timing
- Reset values: `out`=1, `sending`=0, `frame_done`=0, `din_ready`=1, `fifo_count`=0, FSM in IDLE, FIFO pointers 0.
- Reset mid-frame aborts the frame immediately (asynchronous), forces `out` high and discards FIFO contents.
- All outputs are registered.
- Latency: a word pushed at edge k into an empty FIFO with the FSM idle gives `out`=0 and `sending`=1 from edge k+2.
- `fifo_count` reflects that push from edge k+1.
- Back-to-back frames: the next START begins on the cycle after the last STOP cycle, with zero idle gap.
- `frame_done` asserts on the final cycle of the frame, concurrent with that cycle's `out`=1.
- Total frame duration is `divisor` times the frame length, exactly.

## Test plan
- 8N1, `divisor`=4, push 0xA5:
  - `out` shows 0, then 1,0,1,0,0,1,0,1, then 1, each level for 4 cycles.
  - Start falls at edge k+2.
  - `frame_done` pulses once at cycle k+41.
  - `sending` returns to 0.
- 8O2, `divisor`=3, push 0xA5: parity bit is 1 and two stop bits follow; frame is 36 cycles. Repeat with even parity: parity bit is 0.
- FIFO_DEPTH=4, `divisor`=2:
  - Push 6 words with `din_valid` held high.
  - `din_ready` drops when `fifo_count`=4.
  - All accepted words appear on `out` in order with no idle gap.
  - `sending` stays high throughout.
  - Exactly 5 `frame_done` pulses occur for 5 accepted words.
- Reset asserted in the middle of the data bits of the second queued frame:
  - `out`=1, `sending`=0 and `fifo_count`=0 immediately, without waiting for a clock edge.
  - After release, a new push transmits correctly.
- `divisor`=0 and `divisor`=1 each give 2-cycle bits. Changing `divisor` mid-frame does not alter the current frame.
- DATA_BITS=5 instance, 5N1, push 5'b10011: `out` sequence is 0, then 1,1,0,0,1, then 1.
